// File: rtl/register_file_pkg.sv
// Shared types and default parameter values for the multi-port register file.
// Holds the clear-walk state encoding used by the clear sequencer.
`default_nettype none

package register_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_ZERO_R0 = 1;
  localparam int DEF_BYPASS  = 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/register_file_clr_fsm.sv
// Clear sequencer: walks every array index once, writing zero, after reset or on request.
// Revision: 1.0
`default_nettype none

module register_file_clr_fsm
  import register_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] idx_q;

  // Reset lands in CLEAR so the array is scrubbed before first use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
          end
        end
        CLEAR: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (&idx_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = idx_q;

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// Multi-read-port, dual-write-port register file with optional r0 hardwiring,
// write-to-read bypass and a walking clear. Revision: 1.0
`default_nettype none

module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = DEF_ZERO_R0,
  parameter int BYPASS  = DEF_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wen0;
  logic              wen1;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  register_file_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to r0 are swallowed silently; this also keeps r0 out of the bypass.
  assign wen0 = we0 && !busy && !((ZERO_R0 != 0) && (waddr0 == '0));
  assign wen1 = we1 && !busy && !((ZERO_R0 != 0) && (waddr1 == '0));

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_we && (clr_addr == ADDR_W'(i))) begin
        mem_q[i] <= '0;
      end else if (wen1 && (waddr1 == ADDR_W'(i))) begin
        mem_q[i] <= wdata1;
      end else if (wen0 && (waddr0 == ADDR_W'(i))) begin
        mem_q[i] <= wdata0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= busy && (we0 || we1);
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      if (BYPASS != 0) begin
        if (wen0 && (waddr0 == ra)) rd = wdata0;
        if (wen1 && (waddr1 == ra)) rd = wdata1;
      end
      if (busy || ((ZERO_R0 != 0) && (ra == '0))) rd = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd;
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
`default_nettype none

module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  waddr0 = '0, waddr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr_drop;

  register_file_mp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .we0     (we0),
    .we1     (we1),
    .waddr0  (waddr0),
    .waddr1  (waddr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        busy;
    logic        drop;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: register contents, remaining clear cycles, pending drop flag.
  logic [31:0] m [32];
  int          clr_left;
  bit          drop_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd0",  64'(rd_data[31:0]),  64'(e.rd0));
      chk("rd1",  64'(rd_data[63:32]), 64'(e.rd1));
      chk("busy", 64'(busy),           64'(e.busy));
      chk("drop", 64'(wr_drop),        64'(e.drop));
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit b,
      input bit iwe0, input logic [4:0] wa0, input logic [31:0] wd0,
      input bit iwe1, input logic [4:0] wa1, input logic [31:0] wd1);
    if (b || a == 5'd0) return 32'd0;
    if (iwe1 && wa1 == a) return wd1;
    if (iwe0 && wa0 == a) return wd0;
    return m[a];
  endfunction

  // Drive one cycle: inputs set just after a rising edge, checked at the falling edge.
  task automatic step(input bit iwe0, input logic [4:0] wa0, input logic [31:0] wd0,
                      input bit iwe1, input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [4:0] ra1, input bit iclr);
    exp_t e;
    bit   b;
    we0 = iwe0; waddr0 = wa0; wdata0 = wd0;
    we1 = iwe1; waddr1 = wa1; wdata1 = wd1;
    rd_addr = {ra1, ra0};
    clr_req = iclr;
    b = (clr_left > 0);
    e.busy = b;
    e.drop = drop_exp;
    e.rd0  = model_read(ra0, b, iwe0, wa0, wd0, iwe1, wa1, wd1);
    e.rd1  = model_read(ra1, b, iwe0, wa0, wd0, iwe1, wa1, wd1);
    exp_q.push_back(e);
    drop_exp = b && (iwe0 || iwe1);
    if (b) begin
      clr_left--;
    end else begin
      if (iwe0 && wa0 != 5'd0) m[wa0] = wd0;
      if (iwe1 && wa1 != 5'd0) m[wa1] = wd1;
      if (iclr) begin
        clr_left = 32;
        foreach (m[i]) m[i] = 32'd0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ra0, ra1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_drop", 64'(wr_drop), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_left = 32;
    drop_exp = 1'b0;
    foreach (m[i]) m[i] = 32'd0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 100) begin
      idle(5'd1, 5'd2);
      n++;
    end
    chk(name, 64'(n), 64'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    clr_left = 32;
    drop_exp = 1'b0;
    foreach (m[i]) m[i] = 32'd0;
    @(posedge clk);
    #1;
    do_reset();
    count_busy("busy_len_reset");

    for (int a = 0; a < 32; a += 2) idle(5'(a), 5'(a + 1));

    // Bypass on a plain write, then the stored value.
    step(1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 32'd0, 5'd5, 5'd4, 0);
    chk("byp5", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    idle(5'd5, 5'd5);

    // Same-address collision: port 1 wins in array and bypass.
    step(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 5'd7, 5'd7, 0);
    idle(5'd7, 5'd0);

    // r0 ignores writes and never flags a drop.
    step(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0);
    idle(5'd0, 5'd7);

    // Write during clear is dropped; the clear leaves reg3 at zero.
    step(1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 5'd3, 5'd0, 0);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd7, 1);
    idle(5'd3, 5'd3);
    step(1, 5'd3, 32'h44, 0, 5'd0, 32'd0, 5'd3, 5'd3, 0);
    chk("drop_seen", 64'(wr_drop), 64'd1);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd3, 1);
    for (int i = 0; i < 40 && busy; i++) idle(5'd3, 5'd7);
    idle(5'd3, 5'd7);

    // Reset mid-clear restarts the full walk.
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd1, 5'd2, 1);
    repeat (10) idle(5'd1, 5'd2);
    do_reset();
    count_busy("busy_len_midclr");

    for (int i = 0; i < 400; i++) begin
      bit          r_we0, r_we1, r_clr;
      logic [4:0]  a0, a1;
      r_we0 = ($urandom_range(0, 2) != 0);
      r_we1 = ($urandom_range(0, 3) == 0);
      a0 = 5'($urandom_range(0, 31));
      a1 = r_we0 ? a0 : 5'($urandom_range(0, 31));
      r_clr = ($urandom_range(0, 59) == 0);
      step(r_we0, a0, $urandom(), r_we1, a1, $urandom(),
           ($urandom_range(0, 1) != 0) ? a0 : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), r_clr);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4: number of read ports.
REQ-004 SHALL have parameter ZERO_R0, default 1: 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port clr_req, input, 1: pulse that starts a full-array clear.
REQ-009 SHALL have port busy, output, 1: clear in progress.
REQ-010 SHALL have ports we0/we1, input, 1 each: write enables; port 1 has priority.
REQ-011 SHALL have ports waddr0/waddr1, input, ADDR_W each: write addresses.
REQ-012 SHALL have ports wdata0/wdata1, input, DATA_W each: write data.
REQ-013 SHALL have port rd_addr, input, NUM_RD*ADDR_W: packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-014 SHALL have port rd_data, output, NUM_RD*DATA_W: packed read data, same packing.
REQ-015 SHALL have port wr_drop, output, 1: registered pulse, a write was discarded.

Function
REQ-016 Reads SHALL be combinational from the array; no read latency.
REQ-017 Writes SHALL update the array on the rising clk edge when the write enable is high and busy is low.
REQ-018 When we0 and we1 target the same address in one cycle, SHALL store wdata1 only.
REQ-019 With BYPASS=1, a read whose address matches an active write SHALL return that write data in the same cycle (wdata1 when both match); with BYPASS=0, it SHALL return the old contents.
REQ-020 With ZERO_R0=1, writes to address 0 SHALL be ignored without asserting wr_drop, reads of address 0 SHALL return 0, and bypass SHALL NOT apply to address 0.
REQ-021 Clear FSM SHALL have states IDLE and CLEAR, with an ADDR_W-bit index counter.
REQ-022 CLEAR SHALL write 0 to array[idx] each cycle and increment idx; at idx = DEPTH-1 it SHALL write and go to IDLE; clear takes exactly DEPTH cycles.
REQ-023 IDLE with clr_req=1 SHALL go to CLEAR with idx=0; clr_req in CLEAR SHALL be ignored (no restart).
REQ-024 busy SHALL be 1 exactly while the state is CLEAR.
REQ-025 While busy=1, rd_data SHALL be all zeros on every port.
REQ-026 Any we0/we1 asserted while busy=1 SHALL be discarded, and wr_drop SHALL be 1 on the following cycle.
REQ-027 wr_drop SHALL be 0 whenever no write was discarded in the prior cycle.
REQ-028 The first write accepted after busy falls SHALL see the whole array at 0.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force state=CLEAR, idx=0, busy=1 and wr_drop=0, independent of clk.
REQ-030 Array contents SHALL NOT be reset directly; they SHALL be zeroed by the CLEAR walk after rst_n rises.
REQ-031 Reset asserted mid-clear SHALL restart the walk from idx 0.

Structure
REQ-032 Package register_file_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the parameter default constants.
REQ-033 The clear FSM and counter SHALL be sub-module register_file_clr_fsm (ports clk, rst_n, clr_req, busy, clr_we, clr_addr).
REQ-034 The array SHALL be one DEPTH x DATA_W memory with a single write path muxed clear > we1 > we0.

Verification
REQ-035 Reset, then rst_n=1 -> busy=1 for exactly 32 cycles, then 0; all 32 registers read 0.
REQ-036 we0 waddr0=5 wdata0=0xA5A5A5A5 -> same-cycle rd port0 addr5 = 0xA5A5A5A5 (BYPASS=1); next cycle also 0xA5A5A5A5.
REQ-037 we0 and we1 both addr 7, data 0x11 / 0x22 -> reg7 = 0x22; the same-cycle bypass read returns 0x22.
REQ-038 Write 0xFFFFFFFF to addr 0 -> reads 0, wr_drop stays 0.
REQ-039 clr_req with reg3=0x33, then we0 addr3 0x44 on cycle 2 of the clear -> wr_drop=1 on the next cycle; after busy falls, reg3=0.
REQ-040 rst_n pulsed low at idx=10 of a clear -> busy stays 1; 32 further cycles occur after rst_n rises before busy falls.
